xc_rf_wb_arb: RTL and testbench
===============================

Name: xc_rf_wb_arb

Overview:
Write-back arbiter directly upstream of the forwarding register file. It merges two result sources into the single register-file write port (rd_wen/rd_addr/rd_wdata):
- the in-order pipeline, which cannot stall its write-back;
- a multi-cycle coprocessor unit, which uses a valid/ready handshake.
Coprocessor results are buffered in a small FIFO and drained into idle write-port cycles. Pending-write flags let decode stall on RAW hazards.

Parameters:
DEPTH, 2, coprocessor result FIFO entries (power of two, >=2)
STARVE_MAX, 8, cycles a non-empty FIFO may wait before stall_req is raised (only with the optional feature)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
p_wen  in  1  pipeline write-back valid (no back-pressure)
p_addr  in  5  pipeline destination register
p_wdata  in  32  pipeline result
c_valid  in  1  coprocessor result valid
c_ready  out  1  coprocessor result accepted this cycle
c_addr  in  5  coprocessor destination register
c_wdata  in  32  coprocessor result
rs1_addr  in  5  decode source 1 address
rs2_addr  in  5  decode source 2 address
rs1_pending  out  1  rs1_addr has an outstanding coprocessor write
rs2_pending  out  1  rs2_addr has an outstanding coprocessor write
stall_req  out  1  request for pipeline to leave a write-back bubble
rd_wen  out  1  registered write enable to register file
rd_addr  out  5  registered write address
rd_wdata  out  32  registered write data

Behaviour:
- Reset (async, resetn low): FIFO empty, pointers 0, starve counter 0. Outputs: rd_wen=0, rd_addr=0, rd_wdata=0, stall_req=0. c_ready=1 once reset is released.
- Handshake:
  - c_ready = FIFO not full, computed from registered state only (no combinational path from pop).
  - Transfer when c_valid && c_ready.
  - c_addr==0 transfers complete but are discarded (not enqueued).
- Pipeline writes with p_addr==0 are treated as p_wen=0.
- Arbitration, evaluated each cycle:
  - Effective p_wen=1: rd_* <= pipeline values next edge.
  - Else, FIFO non-empty: pop head and rd_* <= head next edge.
  - Else: rd_wen <= 0, rd_addr/rd_wdata hold.
- Latency:
  - Pipeline write reaches rd_* 1 cycle after p_wen.
  - A coprocessor result accepted into an empty FIFO at edge N reaches rd_* at edge N+1 at the earliest.
  - FIFO is not bypassed.
- Simultaneous push and pop: allowed. Occupancy is unchanged. When full, c_ready stays 0 in that cycle.
- Wrap-around: pointers are log2(DEPTH)+1 bits; full/empty are decided by the MSB compare.
- Pending flags: rsX_pending = 1 if rsX_addr!=0 and it matches any valid FIFO entry, or matches rd_addr while rd_wen=1 and that write came from the FIFO.
- Ordering: decode must stall while rsX_pending, and must not issue a pipeline write to a register with a pending coprocessor write. Under that rule, write order per register equals issue order.
- Reset mid-operation: all FIFO contents are dropped. In-flight coprocessor results are lost and the coprocessor is reset by the same resetn.

Optional Feature:
XC_WB_ARB_STARVE_EN
- Defined:
  - A counter increments each cycle the FIFO is non-empty and a pop is blocked by the pipeline; it clears on any pop and saturates at STARVE_MAX.
  - stall_req is registered and set when the counter reaches STARVE_MAX; it clears the cycle after a pop.
  - If the pipeline writes while stall_req=1, the pipeline still wins.
- Undefined: no counter; stall_req tied to 0.

Test Plan:
- Reset, then p_wen=1 p_addr=5 p_wdata=0xDEADBEEF for one cycle -> next cycle rd_wen=1 rd_addr=5 rd_wdata=0xDEADBEEF, then rd_wen=0.
- Coprocessor push addr=7 data=0x11 with pipeline idle -> c_ready=1, rd_wen=1 addr=7 data=0x11 one cycle later. rs1_addr=7 gives rs1_pending=1 until the rd_wen cycle ends.
- Pipeline writing every cycle, coprocessor pushes 3 results (DEPTH=2) -> first two accepted, c_ready=0 on the third. When the pipeline idles, writes drain in order with no loss.
- Same-cycle p_wen=1 addr=3 and FIFO head addr=9 -> rd_addr=3 first, addr=9 the following idle cycle.
- c_valid with c_addr=0 and p_wen with p_addr=0 -> handshake completes, rd_wen stays 0, FIFO stays empty.
- With XC_WB_ARB_STARVE_EN, STARVE_MAX=8, FIFO holding one entry and the pipeline writing continuously -> stall_req=1 after 8 blocked cycles. It drops the cycle after the first idle pop. Without the macro, stall_req stays 0.

Source files
------------

// File: rtl/xc_rf_wb_arb_if.sv
// xc_rf_wb_arb_if: write-back arbiter bus bundle.
// Groups the pipeline write-back, the coprocessor result handshake,
// the decode hazard lookup and the register-file write port.
// slave  : the arbiter side
// master : the environment side (pipeline, coprocessor, decode, regfile)
`timescale 1ns/1ps
interface xc_rf_wb_arb_if;
  // pipeline write-back (no back-pressure)
  logic        p_wen;
  logic [4:0]  p_addr;
  logic [31:0] p_wdata;
  // coprocessor result handshake
  logic        c_valid;
  logic        c_ready;
  logic [4:0]  c_addr;
  logic [31:0] c_wdata;
  // decode hazard lookup
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_pending;
  logic        rs2_pending;
  logic        stall_req;
  // register-file write port
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;

  modport slave (
    input  p_wen, p_addr, p_wdata,
    input  c_valid, c_addr, c_wdata,
    output c_ready,
    input  rs1_addr, rs2_addr,
    output rs1_pending, rs2_pending, stall_req,
    output rd_wen, rd_addr, rd_wdata
  );

  modport master (
    output p_wen, p_addr, p_wdata,
    output c_valid, c_addr, c_wdata,
    input  c_ready,
    output rs1_addr, rs2_addr,
    input  rs1_pending, rs2_pending, stall_req,
    input  rd_wen, rd_addr, rd_wdata
  );
endinterface

// File: rtl/xc_rf_wb_arb.sv
// xc_rf_wb_arb: write-back arbiter in front of the forwarding register file.
// Merges the in-order pipeline write-back (always wins) with buffered
// coprocessor results, which drain into idle write-port cycles.
// Pending flags expose outstanding coprocessor writes to decode.
// Optional feature macro: XC_WB_ARB_STARVE_EN (starvation counter that
// drives stall_req; when undefined stall_req is tied low).
`timescale 1ns/1ps
module xc_rf_wb_arb #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clock,
  input  logic          resetn,
  xc_rf_wb_arb_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef logic [PW:0] ptr_t;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

  // FIFO state
  ptr_t            wr_ptr_r;
  ptr_t            rd_ptr_r;
  ptr_t            count_s;
  logic [AW-1:0]   mem_addr_r [DEPTH];
  logic [DW-1:0]   mem_data_r [DEPTH];
  logic [DEPTH-1:0] entry_valid_s;
  logic [AW-1:0]   head_addr_s;
  logic [DW-1:0]   head_data_s;

  // control
  logic            full_s;
  logic            empty_s;
  logic            p_eff_s;
  logic            push_s;
  logic            pop_s;

  // write port registers
  logic            rd_wen_r;
  logic [AW-1:0]   rd_addr_r;
  logic [DW-1:0]   rd_wdata_r;
  logic            from_fifo_r;

  // hazard lookup
  logic            rs1_hit_s;
  logic            rs2_hit_s;
  logic            rs1_inflight_s;
  logic            rs2_inflight_s;

  // Full/empty come from registered pointers only, so c_ready has no path from pop.
  assign count_s = wr_ptr_r - rd_ptr_r;
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                   (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);

  assign bus.c_ready = ~full_s;

  // Register 0 is hard-wired, so writes to it are dropped on both sources.
  assign p_eff_s = bus.p_wen & (bus.p_addr != 5'd0);
  assign push_s  = bus.c_valid & ~full_s & (bus.c_addr != 5'd0);
  assign pop_s   = ~p_eff_s & ~empty_s;

  assign head_addr_s = mem_addr_r[rd_ptr_r[PW-1:0]];
  assign head_data_s = mem_data_r[rd_ptr_r[PW-1:0]];

  // FIFO pointers and storage: push writes at the tail, pop advances the head.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_addr_r[i] <= 5'd0;
        mem_data_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        mem_addr_r[wr_ptr_r[PW-1:0]] <= bus.c_addr;
        mem_data_r[wr_ptr_r[PW-1:0]] <= bus.c_wdata;
        wr_ptr_r                     <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Write-port arbitration: pipeline first, then FIFO head, else idle with held data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_wen_r    <= 1'b0;
      rd_addr_r   <= 5'd0;
      rd_wdata_r  <= 32'd0;
      from_fifo_r <= 1'b0;
    end else if (p_eff_s) begin
      rd_wen_r    <= 1'b1;
      rd_addr_r   <= bus.p_addr;
      rd_wdata_r  <= bus.p_wdata;
      from_fifo_r <= 1'b0;
    end else if (pop_s) begin
      rd_wen_r    <= 1'b1;
      rd_addr_r   <= head_addr_s;
      rd_wdata_r  <= head_data_s;
      from_fifo_r <= 1'b1;
    end else begin
      rd_wen_r    <= 1'b0;
      from_fifo_r <= 1'b0;
    end
  end

  assign bus.rd_wen   = rd_wen_r;
  assign bus.rd_addr  = rd_addr_r;
  assign bus.rd_wdata = rd_wdata_r;

  // Mark slots between head and tail (modulo DEPTH) as holding live entries.
  always_comb begin
    entry_valid_s = {DEPTH{1'b0}};
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_valid_s[i] = ({1'b0, PW'(i) - rd_ptr_r[PW-1:0]} < count_s);
    end
  end

  // Search live FIFO entries for the decode source registers.
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rs1_hit_s = rs1_hit_s | (entry_valid_s[i] & (mem_addr_r[i] == bus.rs1_addr));
      rs2_hit_s = rs2_hit_s | (entry_valid_s[i] & (mem_addr_r[i] == bus.rs2_addr));
    end
  end

  // A popped coprocessor result stays pending while it sits on the write port.
  assign rs1_inflight_s = rd_wen_r & from_fifo_r & (rd_addr_r == bus.rs1_addr);
  assign rs2_inflight_s = rd_wen_r & from_fifo_r & (rd_addr_r == bus.rs2_addr);

  assign bus.rs1_pending = (bus.rs1_addr != 5'd0) & (rs1_hit_s | rs1_inflight_s);
  assign bus.rs2_pending = (bus.rs2_addr != 5'd0) & (rs2_hit_s | rs2_inflight_s);

`ifdef XC_WB_ARB_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_r;
  logic [SW-1:0] starve_cnt_next_s;
  logic          stall_req_r;

  // Count cycles where the head is blocked by the pipeline; any pop clears it.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    if (pop_s) begin
      starve_cnt_next_s = {SW{1'b0}};
    end else if (~empty_s && p_eff_s && (starve_cnt_r != SW'(STARVE_MAX))) begin
      starve_cnt_next_s = starve_cnt_r + SW'(1);
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // Starve counter and the registered bubble request derived from it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= {SW{1'b0}};
      stall_req_r  <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
      stall_req_r  <= (starve_cnt_next_s == SW'(STARVE_MAX));
    end
  end

  assign bus.stall_req = stall_req_r;
`else
  assign bus.stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_xc_rf_wb_arb.sv
// tb_xc_rf_wb_arb: scenario tasks for the write-back arbiter.
// Expected register-file writes are queued as stimulus is driven and
// popped when rd_wen is observed. Outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_xc_rf_wb_arb;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 8;
`ifdef XC_WB_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clock;
  logic        resetn;
  int          n_cmp;
  int          n_bad;
  logic [36:0] exp_q [$];

  xc_rf_wb_arb_if bus ();

  xc_rf_wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    bus.p_wen    = 1'b0;
    bus.p_addr   = 5'd0;
    bus.p_wdata  = 32'd0;
    bus.c_valid  = 1'b0;
    bus.c_addr   = 5'd0;
    bus.c_wdata  = 32'd0;
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
  endtask

  task automatic test_reset();
    set_idle();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.stall_req} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_outs got=%h exp=0", {bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.stall_req});
    end
    resetn = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.c_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_c_ready got=%b exp=1", bus.c_ready);
    end
    n_cmp++;
    if (bus.rd_wen !== 1'b0) begin
      n_bad++; $display("FAIL reset_rd_wen got=%b exp=0", bus.rd_wen);
    end
  endtask

  task automatic test_pipe_write();
    logic [36:0] e;
    @(negedge clock);
    bus.p_wen = 1'b1; bus.p_addr = 5'd5; bus.p_wdata = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clock);
    bus.p_wen = 1'b0;
    n_cmp++;
    e = exp_q.pop_front();
    if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata} !== {1'b1, e}) begin
      n_bad++; $display("FAIL pipe_write got=%h exp=%h", {bus.rd_wen, bus.rd_addr, bus.rd_wdata}, {1'b1, e});
    end
    @(negedge clock);
    n_cmp++;
    if (bus.rd_wen !== 1'b0) begin
      n_bad++; $display("FAIL pipe_write_idle got=%b exp=0", bus.rd_wen);
    end
  endtask

  task automatic test_cop_push();
    logic [36:0] e;
    @(negedge clock);
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd8;
    #1;
    n_cmp++;
    if (bus.c_ready !== 1'b1) begin
      n_bad++; $display("FAIL cop_c_ready got=%b exp=1", bus.c_ready);
    end
    n_cmp++;
    if (bus.rs1_pending !== 1'b0) begin
      n_bad++; $display("FAIL cop_pend_before got=%b exp=0", bus.rs1_pending);
    end
    bus.c_valid = 1'b1; bus.c_addr = 5'd7; bus.c_wdata = 32'h11;
    exp_q.push_back({5'd7, 32'h11});
    @(negedge clock);
    bus.c_valid = 1'b0;
    n_cmp++;
    if ({bus.rd_wen, bus.rs1_pending, bus.rs2_pending} !== 3'b010) begin
      n_bad++; $display("FAIL cop_queued got=%b exp=010", {bus.rd_wen, bus.rs1_pending, bus.rs2_pending});
    end
    @(negedge clock);
    n_cmp++;
    e = exp_q.pop_front();
    if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.rs1_pending} !== {1'b1, e, 1'b1}) begin
      n_bad++; $display("FAIL cop_write got=%h exp=%h", {bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.rs1_pending}, {1'b1, e, 1'b1});
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.rd_wen, bus.rs1_pending} !== 2'b00) begin
      n_bad++; $display("FAIL cop_done got=%b exp=00", {bus.rd_wen, bus.rs1_pending});
    end
    set_idle();
  endtask

  task automatic test_fifo_full();
    logic [36:0] cop_q [$];
    logic [36:0] e;
    logic        exp_rdy;
    logic        acc;
    int          guard;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k > 0) begin
        n_cmp++;
        e = exp_q.pop_front();
        if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata} !== {1'b1, e}) begin
          n_bad++; $display("FAIL full_pipe%0d got=%h exp=%h", k, {bus.rd_wen, bus.rd_addr, bus.rd_wdata}, {1'b1, e});
        end
      end
      exp_rdy = (k < 2) ? 1'b1 : 1'b0;
      n_cmp++;
      if (bus.c_ready !== exp_rdy) begin
        n_bad++; $display("FAIL full_c_ready%0d got=%b exp=%b", k, bus.c_ready, exp_rdy);
      end
      bus.p_wen = 1'b1; bus.p_addr = 5'(10 + k); bus.p_wdata = 32'hA000_0000 + 32'(k);
      exp_q.push_back({5'(10 + k), 32'hA000_0000 + 32'(k)});
      bus.c_valid = 1'b1;
      if (k < 3) begin
        bus.c_addr = 5'(20 + k); bus.c_wdata = 32'h100 + 32'(k);
        cop_q.push_back({5'(20 + k), 32'h100 + 32'(k)});
      end
    end
    @(negedge clock);
    n_cmp++;
    e = exp_q.pop_front();
    if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.c_ready} !== {1'b1, e, 1'b0}) begin
      n_bad++; $display("FAIL full_last got=%h exp=%h", {bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.c_ready}, {1'b1, e, 1'b0});
    end
    bus.p_wen = 1'b0;
    while (cop_q.size() > 0) exp_q.push_back(cop_q.pop_front());
    acc = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 12) begin
      @(negedge clock);
      guard++;
      if (acc) bus.c_valid = 1'b0;
      acc = bus.c_valid & bus.c_ready;
      if (bus.rd_wen === 1'b1) begin
        n_cmp++;
        e = exp_q.pop_front();
        if ({bus.rd_addr, bus.rd_wdata} !== e) begin
          n_bad++; $display("FAIL full_drain got=%h exp=%h", {bus.rd_addr, bus.rd_wdata}, e);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL full_drain_timeout left=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    set_idle();
    @(negedge clock);
    n_cmp++;
    if (bus.rd_wen !== 1'b0) begin
      n_bad++; $display("FAIL full_after got=%b exp=0", bus.rd_wen);
    end
  endtask

  task automatic test_priority();
    logic [36:0] e;
    @(negedge clock);
    bus.c_valid = 1'b1; bus.c_addr = 5'd9; bus.c_wdata = 32'h99;
    bus.p_wen = 1'b1; bus.p_addr = 5'd2; bus.p_wdata = 32'h22;
    exp_q.push_back({5'd2, 32'h22});
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_cmp++;
      e = exp_q.pop_front();
      if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata} !== {1'b1, e}) begin
        n_bad++; $display("FAIL prio%0d got=%h exp=%h", k, {bus.rd_wen, bus.rd_addr, bus.rd_wdata}, {1'b1, e});
      end
      if (k == 0) begin
        bus.c_valid = 1'b0;
        bus.p_addr = 5'd3; bus.p_wdata = 32'h33;
        exp_q.push_back({5'd3, 32'h33});
        exp_q.push_back({5'd9, 32'h99});
      end else begin
        bus.p_wen = 1'b0;
      end
    end
    @(negedge clock);
    n_cmp++;
    if (bus.rd_wen !== 1'b0) begin
      n_bad++; $display("FAIL prio_idle got=%b exp=0", bus.rd_wen);
    end
    set_idle();
  endtask

  task automatic test_zero_addr();
    @(negedge clock);
    bus.c_valid = 1'b1; bus.c_addr = 5'd0; bus.c_wdata = 32'h55;
    bus.p_wen = 1'b1; bus.p_addr = 5'd0; bus.p_wdata = 32'h66;
    n_cmp++;
    if (bus.c_ready !== 1'b1) begin
      n_bad++; $display("FAIL zero_c_ready got=%b exp=1", bus.c_ready);
    end
    @(negedge clock);
    set_idle();
    n_cmp++;
    if ({bus.rd_wen, bus.c_ready} !== 2'b01) begin
      n_bad++; $display("FAIL zero_first got=%b exp=01", {bus.rd_wen, bus.c_ready});
    end
    @(negedge clock);
    n_cmp++;
    if (bus.rd_wen !== 1'b0) begin
      n_bad++; $display("FAIL zero_no_drain got=%b exp=0", bus.rd_wen);
    end
  endtask

  task automatic test_starve();
    logic [36:0] e;
    logic        exp_stall;
    @(negedge clock);
    bus.c_valid = 1'b1; bus.c_addr = 5'd12; bus.c_wdata = 32'hC0DE;
    bus.p_wen = 1'b1; bus.p_addr = 5'd1; bus.p_wdata = 32'h1000;
    exp_q.push_back({5'd1, 32'h1000});
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      if (n == 1) bus.c_valid = 1'b0;
      n_cmp++;
      e = exp_q.pop_front();
      if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata} !== {1'b1, e}) begin
        n_bad++; $display("FAIL starve_wr%0d got=%h exp=%h", n, {bus.rd_wen, bus.rd_addr, bus.rd_wdata}, {1'b1, e});
      end
      exp_stall = STARVE_ON && (n >= 9);
      n_cmp++;
      if (bus.stall_req !== exp_stall) begin
        n_bad++; $display("FAIL starve_stall%0d got=%b exp=%b", n, bus.stall_req, exp_stall);
      end
      if (n < 10) begin
        bus.p_addr = 5'(n + 1); bus.p_wdata = 32'h1000 + 32'(n);
        exp_q.push_back({5'(n + 1), 32'h1000 + 32'(n)});
      end else begin
        bus.p_wen = 1'b0;
        exp_q.push_back({5'd12, 32'hC0DE});
      end
    end
    @(negedge clock);
    n_cmp++;
    e = exp_q.pop_front();
    if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.stall_req} !== {1'b1, e, 1'b0}) begin
      n_bad++; $display("FAIL starve_pop got=%h exp=%h", {bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.stall_req}, {1'b1, e, 1'b0});
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.rd_wen, bus.stall_req} !== 2'b00) begin
      n_bad++; $display("FAIL starve_after got=%b exp=00", {bus.rd_wen, bus.stall_req});
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.rs1_addr = 5'd15;
    bus.c_valid = 1'b1; bus.c_addr = 5'd15; bus.c_wdata = 32'hF00D;
    bus.p_wen = 1'b1; bus.p_addr = 5'd1; bus.p_wdata = 32'h1;
    @(negedge clock);
    bus.c_valid = 1'b0;
    bus.p_addr = 5'd2; bus.p_wdata = 32'h2;
    n_cmp++;
    if (bus.rs1_pending !== 1'b1) begin
      n_bad++; $display("FAIL rmid_pending got=%b exp=1", bus.rs1_pending);
    end
    @(negedge clock);
    bus.p_wen = 1'b0;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rd_wen, bus.rd_addr, bus.rs1_pending} !== 7'd0) begin
      n_bad++; $display("FAIL rmid_in_reset got=%h exp=0", {bus.rd_wen, bus.rd_addr, bus.rs1_pending});
    end
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clock);
      n_cmp++;
      if ({bus.rd_wen, bus.rs1_pending} !== 2'b00) begin
        n_bad++; $display("FAIL rmid_dropped got=%b exp=00", {bus.rd_wen, bus.rs1_pending});
      end
    end
    set_idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    resetn = 1'b0;
    set_idle();
    test_reset();
    test_pipe_write();
    test_cop_push();
    test_fifo_full();
    test_priority();
    test_zero_addr();
    test_starve();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
